csa_seq_adder: RTL and testbench



---
 rtl/csa_pkg.sv | 18 +
 rtl/csa_chunk_add.sv | 25 ++
 rtl/csa_seq_adder.sv | 124 ++++++++++++
 tb/tb_csa_seq_adder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and constants for the sequential conditional-sum adder controller.
// The subtract feature of csa_seq_adder is enabled with the CSA_SEQ_SUB_EN macro.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    localparam int DEF_OP_WIDTH = 64;
    localparam int DEF_CHUNK    = 16;

    function automatic int nchunk(input int op_w, input int ch_w);
        return op_w / ch_w;
    endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// One CHUNK-wide conditional sum adder slice: both carry-in cases are formed in
// parallel and the incoming carry picks one, so the carry only crosses a mux.
module csa_chunk_add #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] sum0;
    logic [CHUNK:0] sum1;

    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(1);

    assign {cout, sum} = cin ? sum1 : sum0;

    // Carry into the top bit, recovered from that bit's sum and operands.
    assign c_msb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/csa_seq_adder.sv
// Multi-cycle wide adder: walks OP_WIDTH operands through one CHUNK-bit adder slice.
// Define CSA_SEQ_SUB_EN to add the sub port (a - b with borrow-in = cin).
module csa_seq_adder
    import csa_pkg::*;
#(
    parameter int OP_WIDTH = DEF_OP_WIDTH,
    parameter int CHUNK    = DEF_CHUNK
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] a,
    input  logic [OP_WIDTH-1:0] b,
    input  logic                cin,
`ifdef CSA_SEQ_SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_WIDTH-1:0] sum,
    output logic                cout,
    output logic                ovf,
    output logic                busy
);

    localparam int NCHUNK = nchunk(OP_WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    csa_state_e state, state_nxt;

    logic [IDX_W-1:0]          idx;
    logic [OP_WIDTH-1:0]       a_q;
    logic [OP_WIDTH-1:0]       b_q;
    logic [OP_WIDTH-1:0]       res_q;
    logic                      carry_q;
    logic                      cout_q;
    logic                      ovf_q;
    logic [CHUNK-1:0]          slice;
    logic                      chunk_cout;
    logic                      chunk_cmsb;
    logic                      last;
    logic [OP_WIDTH+CHUNK-1:0] res_cat;

    csa_chunk_add #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .cin   (carry_q),
        .sum   (slice),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    assign last    = (idx == LAST_IDX);
    // New slice enters at the top; after NCHUNK shifts slice 0 sits at the bottom.
    assign res_cat = {slice, res_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
`ifdef CSA_SEQ_SUB_EN
                        b_q     <= sub ? ~b : b;
                        carry_q <= cin ^ sub;
`else
                        b_q     <= b;
                        carry_q <= cin;
`endif
                        idx <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    res_q   <= res_cat[OP_WIDTH+CHUNK-1:CHUNK];
                    carry_q <= chunk_cout;
                    idx     <= idx + IDX_W'(1);
                    if (last) begin
                        cout_q <= chunk_cout;
                        ovf_q  <= chunk_cmsb ^ chunk_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_seq_adder.sv
// Self-checking bench for csa_seq_adder at default widths (64-bit operands, 16-bit chunks).
module tb_csa_seq_adder;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    csa_seq_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CSA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic; overflow when like-signed operands give an unlike-signed sum.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                               input logic rcin, input logic rsub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         o;
        bb   = rsub ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, bb} + (W+1)'(rcin ^ rsub);
        o    = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
        return {o, full};
    endfunction

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                           input logic tsub, output logic [W-1:0] rs, output logic rc,
                           output logic ro, output int lat);
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rs        = sum;
        rc        = cout;
        ro        = ovf;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t         vt[$];
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    int           lat;
    logic [W+1:0] exp_v;
    logic [W-1:0] hold_sum;
    logic         hold_c;
    logic         hold_o;
    logic [W-1:0] na;
    logic [W-1:0] nb;
    logic         rsub;

    initial begin
        vt.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0});
        vt.push_back('{64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0,
                       64'h0011_0022_0033_0045, 1'b0, 1'b0});
        vt.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                       64'h8000_0000_0000_0000, 1'b0, 1'b1});
        vt.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                       64'h0, 1'b1, 1'b1});
        vt.push_back('{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b0,
                       64'h0000_0001_0000_0000, 1'b0, 1'b0});
`ifdef CSA_SEQ_SUB_EN
        vt.push_back('{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        vt.push_back('{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0});
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            run_txn(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, rs, rc, ro, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_sum", i), rs, vt[i].s);
            chk($sformatf("vec%0d_cout", i), 64'(rc), 64'(vt[i].c));
            chk($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vt[i].o));
        end

        for (int i = 0; i < 24; i++) begin
            na = {$urandom, $urandom};
            nb = {$urandom, $urandom};
            if (i % 4 == 1) nb = ~na;
`ifdef CSA_SEQ_SUB_EN
            rsub = 1'($urandom_range(0, 1));
`else
            rsub = 1'b0;
`endif
            exp_v = ref_model(na, nb, 1'($urandom_range(0, 1)) ^ 1'b0, rsub);
            // Recompute with the cin actually driven so the model and DUT see the same request.
            cin = 1'($urandom_range(0, 1));
            exp_v = ref_model(na, nb, cin, rsub);
            run_txn(na, nb, cin, rsub, rs, rc, ro, lat);
            chk($sformatf("rnd%0d_sum", i), rs, exp_v[W-1:0]);
            chk($sformatf("rnd%0d_cout", i), 64'(rc), 64'(exp_v[W]));
            chk($sformatf("rnd%0d_ovf", i), 64'(ro), 64'(exp_v[W+1]));
        end

        // Back-pressure in DONE with a competing request held high.
        exp_v = ref_model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        @(negedge clk);
        a        = 64'h1234_5678_9ABC_DEF0;
        b        = 64'h0FED_CBA9_8765_4321;
        cin      = 1'b1;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'd4);
        hold_sum = sum;
        hold_c   = cout;
        hold_o   = ovf;
        chk("bp_sum", hold_sum, exp_v[W-1:0]);
        na       = 64'h0000_0000_0000_00FF;
        nb       = 64'h0000_0000_0000_0001;
        a        = na;
        b        = nb;
        cin      = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
            chk($sformatf("bp_hold%0d_sum", k), sum, hold_sum);
            chk($sformatf("bp_hold%0d_cout", k), 64'(cout), 64'(hold_c));
            chk($sformatf("bp_hold%0d_ovf", k), 64'(ovf), 64'(hold_o));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_after_hs_in_ready", 64'(in_ready), 64'd1);
        chk("bp_after_hs_valid", 64'(out_valid), 64'd0);
        chk("bp_after_hs_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accept_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_second_latency", 64'(lat), 64'd4);
        chk("bp_second_sum", sum, 64'h100);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset after two RUN cycles aborts the operation.
        @(negedge clk);
        a        = 64'hFFFF_FFFF_FFFF_FFFF;
        b        = 64'hFFFF_FFFF_FFFF_FFFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", sum, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_v = ref_model(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0);
        run_txn(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, rs, rc, ro, lat);
        chk("postrst_latency", 64'(lat), 64'd4);
        chk("postrst_sum", rs, exp_v[W-1:0]);
        chk("postrst_sum_const", rs, 64'h0001_0000_0001_0000);
        chk("postrst_cout", 64'(rc), 64'(exp_v[W]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
